// File: rtl/display_mem_arbiter_if.sv
// display_mem_arbiter_if
//   Groups every non-clock signal of the display memory arbiter.
//   slave  : arbiter view (takes display/writer/clear requests and read
//            data, drives pixel output, grants, clear status, memory bus)
//   master : environment view (VGA timing, game writers, tile RAM)
//   Signals:
//     disp_req, addrh, addrv           display read request and pixel position
//     pix_colour, pix_valid            pixel colour three cycles after sampling
//     w0_*/w1_* req, addr, data, gnt   writer request/grant handshakes
//     clear_start/busy/done            screen-clear sequencer control
//     mem_addr, mem_we, mem_wdata      registered memory command
//     mem_rdata                        synchronous read data from the RAM
interface display_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 12
);
  logic                  disp_req;
  logic [9:0]            addrh;
  logic [8:0]            addrv;
  logic [DATA_WIDTH-1:0] pix_colour;
  logic                  pix_valid;

  logic                  w0_req;
  logic [ADDR_WIDTH-1:0] w0_addr;
  logic [DATA_WIDTH-1:0] w0_data;
  logic                  w0_gnt;
  logic                  w1_req;
  logic [ADDR_WIDTH-1:0] w1_addr;
  logic [DATA_WIDTH-1:0] w1_data;
  logic                  w1_gnt;

  logic                  clear_start;
  logic                  clear_busy;
  logic                  clear_done;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  disp_req, addrh, addrv,
    input  w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data,
    input  clear_start, mem_rdata,
    output pix_colour, pix_valid, w0_gnt, w1_gnt,
    output clear_busy, clear_done, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, addrh, addrv,
    output w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data,
    output clear_start, mem_rdata,
    input  pix_colour, pix_valid, w0_gnt, w1_gnt,
    input  clear_busy, clear_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/display_mem_arbiter.sv
// display_mem_arbiter
//   Shares the single-port tile colour RAM between the VGA scan-out path and
//   two game-logic writers, and runs a hardware screen-clear sequence.
//   Display reads always win the slot; otherwise a running clear writes the
//   next address; otherwise the writers are served round-robin.
//   Ports:
//     clk     pixel clock, rising edge
//     resetn  asynchronous active-low reset
//     bus     display_mem_arbiter_if.slave (see interface header)
module display_mem_arbiter #(
  parameter int TILE_COLS  = 80,
  parameter int TILE_ROWS  = 60,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] CLEAR_COLOUR = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  display_mem_arbiter_if.slave  bus
);

  localparam int DEPTH = TILE_COLS * TILE_ROWS;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clear_cnt, clear_cnt_next;
  logic                  rr_ptr, rr_ptr_next;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_next;
  logic                  mem_we_q, mem_we_next;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_next;
  logic                  w0_gnt_q, w0_gnt_next;
  logic                  w1_gnt_q, w1_gnt_next;
  logic                  clear_busy_q, clear_busy_next;
  logic                  clear_done_q, clear_done_next;
  logic [1:0]            valid_pipe;
  logic [DATA_WIDTH-1:0] pix_colour_q;
  logic                  pix_valid_q;

  logic [ADDR_WIDTH-1:0] tile_addr;
  logic                  w0_elig, w1_elig, grant_w1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // 8x8 pixel tiles: row index times tiles-per-row plus column index.
  assign tile_addr = ADDR_WIDTH'(bus.addrv[8:3]) * ADDR_WIDTH'(TILE_COLS)
                   + ADDR_WIDTH'(bus.addrh[9:3]);

  // A writer whose grant is showing this cycle has already been served;
  // its REQ may still be high from the same transaction.
  assign w0_elig = bus.w0_req && !w0_gnt_q;
  assign w1_elig = bus.w1_req && !w1_gnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      clear_cnt <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
      rr_ptr    <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next      = state;
    clear_cnt_next  = clear_cnt;
    rr_ptr_next     = rr_ptr;
    mem_addr_next   = mem_addr_q;
    mem_we_next     = 1'b0;
    mem_wdata_next  = mem_wdata_q;
    w0_gnt_next     = 1'b0;
    w1_gnt_next     = 1'b0;
    clear_done_next = 1'b0;
    grant_w1        = 1'b0;
    sel_addr        = bus.w0_addr;
    sel_data        = bus.w0_data;

    if (state == IDLE && bus.clear_start) begin
      state_next     = CLEAR;
      clear_cnt_next = '0;
    end

    if (bus.disp_req) begin
      mem_addr_next = tile_addr;
    end else if (state == CLEAR) begin
      mem_addr_next  = clear_cnt;
      mem_we_next    = 1'b1;
      mem_wdata_next = CLEAR_COLOUR;
      if (clear_cnt == LAST_ADDR) begin
        state_next      = IDLE;
        clear_done_next = 1'b1;
      end else begin
        clear_cnt_next = clear_cnt + 1'b1;
      end
    end else if (w0_elig || w1_elig) begin
      // rr_ptr = 1 gives W1 the tie; the pointer always moves to the loser.
      grant_w1    = w1_elig && (!w0_elig || rr_ptr);
      rr_ptr_next = !grant_w1;
      w0_gnt_next = !grant_w1;
      w1_gnt_next = grant_w1;
      sel_addr    = grant_w1 ? bus.w1_addr : bus.w0_addr;
      sel_data    = grant_w1 ? bus.w1_data : bus.w0_data;
      // Out-of-range writes are acknowledged but never reach the RAM.
      if (sel_addr < DEPTH_A) begin
        mem_addr_next  = sel_addr;
        mem_we_next    = 1'b1;
        mem_wdata_next = sel_data;
      end
    end

    clear_busy_next = (state_next == CLEAR);
  end

  // Valid pipe tracks which slots were display reads so that RAM data is only
  // forwarded to the pixel output for those slots.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      w0_gnt_q     <= 1'b0;
      w1_gnt_q     <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      valid_pipe   <= '0;
      pix_colour_q <= '0;
      pix_valid_q  <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_next;
      mem_we_q     <= mem_we_next;
      mem_wdata_q  <= mem_wdata_next;
      w0_gnt_q     <= w0_gnt_next;
      w1_gnt_q     <= w1_gnt_next;
      clear_busy_q <= clear_busy_next;
      clear_done_q <= clear_done_next;
      valid_pipe   <= {valid_pipe[0], bus.disp_req};
      pix_colour_q <= valid_pipe[1] ? bus.mem_rdata : '0;
      pix_valid_q  <= valid_pipe[1];
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.w0_gnt     = w0_gnt_q;
  assign bus.w1_gnt     = w1_gnt_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.clear_done = clear_done_q;
  assign bus.pix_colour = pix_colour_q;
  assign bus.pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_display_mem_arbiter.sv
// tb_display_mem_arbiter
//   Self-checking bench for display_mem_arbiter. Holds a synchronous RAM
//   model on the memory side, queues expected memory writes, display
//   addresses and pixel colours as stimulus is driven, and compares them as
//   the arbiter produces them.
module tb_display_mem_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 12;
  localparam int DEPTH = 4800;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  display_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  display_mem_arbiter #(
    .TILE_COLS(80), .TILE_ROWS(60), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CLEAR_COLOUR(12'h000)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int nAsserts = 0;
  int nFails   = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wrQ[$];
  logic [AW-1:0] addrQ[$];
  logic [DW-1:0] pixQ[$];
  logic [2:0]    vpipe = '0;

  logic [DW-1:0] ram [0:8191];
  logic          fillReq  = 1'b0;
  int            fillMode = 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] fillValue(input int mode, input int addr);
    if (mode == 0) return '0;
    if (addr == 82) return 12'hF0A;
    return DW'((addr * 37 + 5) % 4096);
  endfunction

  // Synchronous single-port RAM: data for the address on the bus appears
  // one cycle later.
  always @(posedge clk) begin
    if (fillReq) begin
      for (int i = 0; i < 8192; i++) ram[i] <= fillValue(fillMode, i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Which of the last three sampled slots were display reads.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) vpipe = '0;
    else         vpipe = {vpipe[1:0], bus.disp_req};
  end

  // Output monitor: pop expectations as the arbiter produces results.
  always @(negedge clk) begin
    if (resetn) begin
      if (vpipe[0]) begin
        if (addrQ.size() == 0) checkOutput("disp_addr_queue", 0, 1);
        else checkOutput("disp_addr", 32'(bus.mem_addr), 32'(addrQ.pop_front()));
        checkOutput("disp_slot_we", 32'(bus.mem_we), 0);
      end else if (bus.mem_we) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", 32'(bus.mem_addr), 32'hFFFF);
        end else begin
          wr_t e;
          e = wrQ.pop_front();
          checkOutput("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
      checkOutput("pix_valid", 32'(bus.pix_valid), 32'(vpipe[2]));
      if (vpipe[2]) begin
        if (pixQ.size() == 0) checkOutput("pix_queue", 0, 1);
        else checkOutput("pix_colour", 32'(bus.pix_colour), 32'(pixQ.pop_front()));
      end else begin
        checkOutput("pix_idle_colour", 32'(bus.pix_colour), 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dreq, input int h, input int v);
    int tile;
    bus.disp_req = dreq;
    bus.addrh    = 10'(h);
    bus.addrv    = 9'(v);
    if (dreq) begin
      tile = (v / 8) * 80 + (h / 8);
      addrQ.push_back(AW'(tile));
      pixQ.push_back(fillValue(fillMode, tile));
    end
  endtask

  task automatic pushWrite(input int a, input int d);
    wr_t e;
    e.addr = AW'(a);
    e.data = DW'(d);
    wrQ.push_back(e);
  endtask

  task automatic fillRam(input int mode);
    fillMode = mode;
    fillReq  = 1'b1;
    tick();
    fillReq  = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_addr"},   32'(bus.mem_addr), 0);
    checkOutput({tag, "_mem_we"},     32'(bus.mem_we), 0);
    checkOutput({tag, "_mem_wdata"},  32'(bus.mem_wdata), 0);
    checkOutput({tag, "_w0_gnt"},     32'(bus.w0_gnt), 0);
    checkOutput({tag, "_w1_gnt"},     32'(bus.w1_gnt), 0);
    checkOutput({tag, "_clear_busy"}, 32'(bus.clear_busy), 0);
    checkOutput({tag, "_clear_done"}, 32'(bus.clear_done), 0);
    checkOutput({tag, "_pix_colour"}, 32'(bus.pix_colour), 0);
    checkOutput({tag, "_pix_valid"},  32'(bus.pix_valid), 0);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    int a0, a1, d0, d1, winner, doneCnt;
    bit granted;

    bus.disp_req = 0; bus.addrh = '0; bus.addrv = '0;
    bus.w0_req = 0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_req = 0; bus.w1_addr = '0; bus.w1_data = '0;
    bus.clear_start = 0;

    // Reset state
    fillRam(1);
    tick(2);
    checkAllZero("reset");
    resetn = 1'b1;
    tick();

    // Single display read of pixel (17,9) -> tile 82
    applyStimulus(1, 17, 9);
    tick();
    checkOutput("disp_mem_addr_82", 32'(bus.mem_addr), 82);
    checkOutput("disp_mem_we_0", 32'(bus.mem_we), 0);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("pix_valid_not_yet", 32'(bus.pix_valid), 0);
    tick();
    checkOutput("pix_colour_latency3", 32'(bus.pix_colour), 32'h0F0A);
    checkOutput("pix_valid_latency3", 32'(bus.pix_valid), 1);
    tick(3);

    // Contention: both writers held, grants alternate starting with W0
    doReset();
    a0 = 10; d0 = 'h111; a1 = 20; d1 = 'h222;
    bus.w0_req = 1; bus.w0_addr = AW'(a0); bus.w0_data = DW'(d0);
    bus.w1_req = 1; bus.w1_addr = AW'(a1); bus.w1_data = DW'(d1);
    for (int k = 0; k < 4; k++) begin
      winner = k % 2;
      if (winner == 0) pushWrite(a0, d0);
      else             pushWrite(a1, d1);
      tick();
      checkOutput($sformatf("rr_w0_gnt_%0d", k), 32'(bus.w0_gnt), 32'(winner == 0));
      checkOutput($sformatf("rr_w1_gnt_%0d", k), 32'(bus.w1_gnt), 32'(winner == 1));
      checkOutput($sformatf("rr_mem_we_%0d", k), 32'(bus.mem_we), 1);
      if (winner == 0) begin
        a0++; d0 += 'h10; bus.w0_addr = AW'(a0); bus.w0_data = DW'(d0);
      end else begin
        a1++; d1 += 'h10; bus.w1_addr = AW'(a1); bus.w1_data = DW'(d1);
      end
    end
    bus.w0_req = 0; bus.w1_req = 0;
    tick();

    // Display reads block both writers; afterwards the pointer favours W0
    bus.w0_req = 1; bus.w0_addr = AW'(30); bus.w0_data = DW'('h333);
    bus.w1_req = 1; bus.w1_addr = AW'(40); bus.w1_data = DW'('h444);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0);
      tick();
      checkOutput("disp_block_w0_gnt", 32'(bus.w0_gnt), 0);
      checkOutput("disp_block_w1_gnt", 32'(bus.w1_gnt), 0);
    end
    applyStimulus(0, 0, 0);
    pushWrite(30, 'h333);
    tick();
    checkOutput("after_block_w0_gnt", 32'(bus.w0_gnt), 1);
    checkOutput("after_block_w1_gnt", 32'(bus.w1_gnt), 0);
    bus.w0_req = 0;
    pushWrite(40, 'h444);
    tick();
    checkOutput("after_block_w1_gnt2", 32'(bus.w1_gnt), 1);
    bus.w1_req = 0;
    tick(3);

    // Out-of-range write is granted but dropped
    bus.w1_req = 1; bus.w1_addr = AW'(DEPTH); bus.w1_data = 12'hFFF;
    tick();
    checkOutput("oor_w1_gnt", 32'(bus.w1_gnt), 1);
    checkOutput("oor_w0_gnt", 32'(bus.w0_gnt), 0);
    checkOutput("oor_mem_we", 32'(bus.mem_we), 0);
    bus.w1_req = 0;
    tick();

    // Pointer moves after a lone grant: W0 alone, then a tie goes to W1
    bus.w0_req = 1; bus.w0_addr = AW'(50); bus.w0_data = DW'('h055);
    pushWrite(50, 'h055);
    tick();
    checkOutput("lone_w0_gnt", 32'(bus.w0_gnt), 1);
    bus.w0_req = 0;
    tick();
    checkOutput("idle_no_gnt", 32'(bus.w0_gnt | bus.w1_gnt), 0);
    bus.w0_req = 1; bus.w0_addr = AW'(51); bus.w0_data = DW'('h066);
    bus.w1_req = 1; bus.w1_addr = AW'(60); bus.w1_data = DW'('h077);
    pushWrite(60, 'h077);
    tick();
    checkOutput("tie_ptr_w1_gnt", 32'(bus.w1_gnt), 1);
    checkOutput("tie_ptr_w0_gnt", 32'(bus.w0_gnt), 0);
    bus.w1_req = 0;
    pushWrite(51, 'h066);
    tick();
    checkOutput("tie_next_w0_gnt", 32'(bus.w0_gnt), 1);
    bus.w0_req = 0;
    tick(3);

    // Scan a band of rows at the top and bottom of the frame
    fillRam(1);
    for (int r = 0; r < 24; r++) begin
      int v;
      v = (r < 16) ? r : 456 + r;
      for (int h = 0; h < 640; h++) begin
        applyStimulus(1, h, v);
        tick();
      end
      applyStimulus(0, 0, 0);
      tick(4);
    end

    // Clear with display toggling and W0 waiting throughout
    fillRam(0);
    bus.clear_start = 1;
    for (int i = 0; i < DEPTH; i++) pushWrite(i, 0);
    tick();
    checkOutput("clear_busy_start", 32'(bus.clear_busy), 1);
    bus.clear_start = 0;
    bus.w0_req = 1; bus.w0_addr = AW'(7); bus.w0_data = DW'('h0AB);
    pushWrite(7, 'h0AB);
    doneCnt = 0;
    granted = 0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      applyStimulus(cyc % 2 == 0, 0, 0);
      tick();
      if (bus.mem_we && bus.mem_addr == AW'(DEPTH - 1)) begin
        checkOutput("clear_done_with_last", 32'(bus.clear_done), 1);
        checkOutput("clear_busy_after_last", 32'(bus.clear_busy), 0);
      end
      if (bus.clear_done) doneCnt++;
      if (bus.w0_gnt) begin
        checkOutput("w0_gnt_busy_low", 32'(bus.clear_busy), 0);
        checkOutput("w0_gnt_after_done", 32'(doneCnt), 1);
        granted = 1;
        bus.w0_req = 0;
        break;
      end
    end
    applyStimulus(0, 0, 0);
    if (!granted) checkOutput("clear_w0_timeout", 0, 1);
    tick(4);
    checkOutput("clear_done_count", 32'(doneCnt), 1);
    checkOutput("clear_writes_drained", 32'(wrQ.size()), 0);

    // Asynchronous reset in the middle of a clear with W0 pending
    bus.clear_start = 1;
    for (int i = 0; i < DEPTH; i++) pushWrite(i, 0);
    tick();
    bus.clear_start = 0;
    bus.w0_req = 1; bus.w0_addr = AW'(9); bus.w0_data = DW'('h0CD);
    tick(50);
    #2;
    resetn = 1'b0;
    #1;
    checkAllZero("async_reset");
    wrQ.delete();
    bus.w0_req = 0;
    tick(2);
    resetn = 1'b1;
    tick();
    checkOutput("post_reset_busy", 32'(bus.clear_busy), 0);
    checkOutput("post_reset_w0_gnt", 32'(bus.w0_gnt), 0);
    checkOutput("post_reset_mem_we", 32'(bus.mem_we), 0);
    bus.w0_req = 1;
    pushWrite(9, 'h0CD);
    tick();
    checkOutput("rerequest_w0_gnt", 32'(bus.w0_gnt), 1);
    checkOutput("rerequest_mem_we", 32'(bus.mem_we), 1);
    bus.w0_req = 0;
    tick(5);
    checkOutput("post_reset_busy_stays_low", 32'(bus.clear_busy), 0);

    checkOutput("wr_queue_drained", 32'(wrQ.size()), 0);
    checkOutput("addr_queue_drained", 32'(addrQ.size()), 0);
    checkOutput("pix_queue_drained", 32'(pixQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
